sysref_trig_align: RTL
======================

Name: sysref_trig_align

Overview:
- Sits directly downstream of the MTS clock/sysref distribution stage, in the ADC_pl_clk domain.
- Consumes the registered user_sysref_adc and detects its rising edges.
- Measures the sysref period and declares lock after repeated equal periods.
- On an arm request, fires a one-cycle capture trigger aligned to the next sysref edge plus a programmable delay, so all tiles start capture on the same sysref-relative cycle.

Parameters:
PERIOD_W, 16, width of period counter and sysref_period output
LOCK_CNT, 4, consecutive matching periods required to assert lock (>=1)
DELAY_W, 8, width of trig_delay
ERR_W, 8, width of saturating lock-loss error counter

Ports:
ADC_pl_clk  in  1  sole clock; all logic on its rising edge
ADC_pl_rst_n  in  1  asynchronous, active-low reset
user_sysref_adc  in  1  sysref level, already registered in ADC_pl_clk domain
arm  in  1  single-cycle request to fire the trigger on the next sysref edge
trig_delay  in  DELAY_W  cycles after the sysref edge event before trig_out
clr_err  in  1  clears err_cnt
trig_out  out  1  one-cycle aligned capture trigger
armed  out  1  high while the FSM is not IDLE
sysref_locked  out  1  periodic sysref confirmed
sysref_period  out  PERIOD_W  last measured edge-to-edge period, in cycles
err_cnt  out  ERR_W  count of lock losses and aborted triggers, saturating

Behaviour:
- Reset: all outputs 0, FSM IDLE, period counter 1, match count 0, first-edge flag clear. Reset is asynchronous. Assertion mid-operation aborts any pending trigger with no trig_out.
- Edge detect: two-flop shift on user_sysref_adc. Let k = first edge that samples the input high. rise_evt is a registered one-cycle pulse in cycle k+2. Pulse width >=1 cycle is accepted; a level held high produces exactly one rise_evt.
- Period counter pcnt:
  - Set to 1 in the cycle after rise_evt; otherwise increments.
  - Saturates at all-ones.
- On rise_evt with no prior edge: set the first-edge flag only.
- On each later rise_evt:
  - sysref_period <= pcnt.
  - If pcnt equals the previous period, match_cnt increments, saturating at LOCK_CNT.
  - Otherwise match_cnt = 0.
  - sysref_locked = 1 when match_cnt reaches LOCK_CNT.
  - Example: sysref every 32 cycles gives sysref_period = 32. Lock asserts on the (LOCK_CNT+2)th edge.
- Lock loss: a mismatched period, or pcnt reaching all-ones while locked. Effects:
  - sysref_locked = 0 and match_cnt = 0.
  - err_cnt increments once, saturating at all-ones.
  - On saturation, the first-edge flag clears and measurement restarts.
- err_cnt:
  - clr_err zeroes err_cnt next cycle.
  - If clr_err coincides with an increment, clear wins.
- FSM states IDLE, ARMED, DELAY:
  - IDLE: arm=1 and sysref_locked=1 moves to ARMED. arm while unlocked is ignored with no error.
  - ARMED: on rise_evt, latch trig_delay into dcnt and move to DELAY. A rise_evt in the same cycle as the arm acceptance is not used; the next edge is.
  - DELAY: if dcnt=0, trig_out=1 for one cycle and return to IDLE. Otherwise dcnt decrements.
  - Timing: trig_out is high in cycle r + trig_delay + 1, where r is the rise_evt cycle.
  - arm while not IDLE is ignored.
  - If trig_delay >= period, the trigger still fires at the computed cycle. Intervening edges are ignored.
- Abort: lock loss while ARMED or DELAY returns the FSM to IDLE with no trig_out. That event counts once in err_cnt.
- armed = (state != IDLE), registered with the state.

Decomposition:
- Shared package mts_pkg holds:
  - FSM state enum (IDLE/ARMED/DELAY).
  - Default widths PERIOD_W/DELAY_W/ERR_W and LOCK_CNT.
- One sub-module, sysref_edge_period, contains the edge detector, period counter, match/lock logic and lock-loss strobe.
- The top holds the trigger FSM, delay counter and err_cnt.

Test Plan:
- Sysref high 4 cycles every 32, LOCK_CNT=4 -> sysref_period=32 after 2nd edge; sysref_locked=1 after 6th edge; err_cnt=0.
- Locked, arm pulse, trig_delay=5 -> trig_out one cycle exactly 6 cycles after next rise_evt; armed high from arm+1 until trig cycle; FSM back in IDLE.
- Locked 32-cycle sysref, one period perturbed to 31 -> sysref_locked drops on that edge; err_cnt=1; relock after 4 further matching periods.
- Armed with trig_delay=20, sysref stopped -> pcnt saturates; lock lost; no trig_out; armed=0; err_cnt increments by exactly 1.
- arm while unlocked, and arm while DELAY -> both ignored; single trig_out only. clr_err coincident with lock loss -> err_cnt=0.
- ADC_pl_rst_n asserted during DELAY -> all outputs 0 immediately; no trig_out after release; relock needed before arm accepted.

Source files
------------

// File: rtl/mts_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mts_pkg: trigger FSM state encoding and default widths shared by the
// sysref alignment logic.                                        rev 1.0
// ---------------------------------------------------------------------------
package mts_pkg;

  localparam int DEF_PERIOD_W = 16;
  localparam int DEF_LOCK_CNT = 4;
  localparam int DEF_DELAY_W  = 8;
  localparam int DEF_ERR_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DELAY = 2'd2
  } trig_state_t;

endpackage
`default_nettype wire

// File: rtl/sysref_edge_period.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sysref_edge_period: sysref rising-edge detect, period measurement, lock
// tracking and a one-cycle lock-loss strobe.                     rev 1.0
// ---------------------------------------------------------------------------
module sysref_edge_period
  import mts_pkg::*;
#(
  parameter int PERIOD_W = DEF_PERIOD_W,
  parameter int LOCK_CNT = DEF_LOCK_CNT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sysref,
  output logic                rise_evt,
  output logic                lock_loss,
  output logic                sysref_locked,
  output logic [PERIOD_W-1:0] sysref_period
);

  localparam int                MW        = $clog2(LOCK_CNT + 1);
  localparam logic [PERIOD_W-1:0] PMAX    = '1;
  localparam logic [MW-1:0]     MATCH_MAX = MW'(LOCK_CNT);

  logic                s0;
  logic                s1;
  logic                have_edge;
  logic [PERIOD_W-1:0] pcnt;
  logic [MW-1:0]       match_cnt;
  logic                mismatch;
  logic                sat;

  assign mismatch  = rise_evt && have_edge && (pcnt != sysref_period);
  assign sat       = !rise_evt && (pcnt == PMAX);
  assign lock_loss = sysref_locked && (mismatch || sat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0            <= 1'b0;
      s1            <= 1'b0;
      rise_evt      <= 1'b0;
      pcnt          <= PERIOD_W'(1);
      have_edge     <= 1'b0;
      match_cnt     <= '0;
      sysref_locked <= 1'b0;
      sysref_period <= '0;
    end else begin
      s0       <= sysref;
      s1       <= s0;
      rise_evt <= s0 & ~s1;

      if (rise_evt)
        pcnt <= PERIOD_W'(1);
      else if (pcnt != PMAX)
        pcnt <= pcnt + 1'b1;

      if (rise_evt) begin
        if (!have_edge) begin
          have_edge <= 1'b1;
        end else begin
          sysref_period <= pcnt;
          if (pcnt == sysref_period) begin
            if (match_cnt != MATCH_MAX)
              match_cnt <= match_cnt + 1'b1;
            sysref_locked <= (match_cnt >= MATCH_MAX - MW'(1));
          end else begin
            match_cnt     <= '0;
            sysref_locked <= 1'b0;
          end
        end
      end else if (sat) begin
        // sysref vanished: forget the first edge and measure from scratch
        have_edge     <= 1'b0;
        match_cnt     <= '0;
        sysref_locked <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sysref_trig_align.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sysref_trig_align: fires a one-cycle capture trigger a programmable number
// of cycles after the next locked sysref edge.                   rev 1.0
// ---------------------------------------------------------------------------
module sysref_trig_align
  import mts_pkg::*;
#(
  parameter int PERIOD_W = DEF_PERIOD_W,
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int DELAY_W  = DEF_DELAY_W,
  parameter int ERR_W    = DEF_ERR_W
) (
  input  logic                ADC_pl_clk,
  input  logic                ADC_pl_rst_n,
  input  logic                user_sysref_adc,
  input  logic                arm,
  input  logic [DELAY_W-1:0]  trig_delay,
  input  logic                clr_err,
  output logic                trig_out,
  output logic                armed,
  output logic                sysref_locked,
  output logic [PERIOD_W-1:0] sysref_period,
  output logic [ERR_W-1:0]    err_cnt
);

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  logic               rise_evt;
  logic               lock_loss;
  trig_state_t        state;
  logic [DELAY_W-1:0] dcnt;

  sysref_edge_period #(
    .PERIOD_W (PERIOD_W),
    .LOCK_CNT (LOCK_CNT)
  ) u_edge_period (
    .clk           (ADC_pl_clk),
    .rst_n         (ADC_pl_rst_n),
    .sysref        (user_sysref_adc),
    .rise_evt      (rise_evt),
    .lock_loss     (lock_loss),
    .sysref_locked (sysref_locked),
    .sysref_period (sysref_period)
  );

  // trig_out is registered one cycle early so it is high exactly while
  // DELAY holds dcnt == 0
  always_ff @(posedge ADC_pl_clk or negedge ADC_pl_rst_n) begin
    if (!ADC_pl_rst_n) begin
      state    <= ST_IDLE;
      armed    <= 1'b0;
      trig_out <= 1'b0;
      dcnt     <= '0;
    end else begin
      trig_out <= 1'b0;
      if (lock_loss && state != ST_IDLE) begin
        state <= ST_IDLE;
        armed <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (arm && sysref_locked && !lock_loss) begin
              state <= ST_ARMED;
              armed <= 1'b1;
            end
          end
          ST_ARMED: begin
            if (rise_evt) begin
              state    <= ST_DELAY;
              dcnt     <= trig_delay;
              trig_out <= (trig_delay == '0);
            end
          end
          ST_DELAY: begin
            if (dcnt == '0) begin
              state <= ST_IDLE;
              armed <= 1'b0;
            end else begin
              dcnt     <= dcnt - 1'b1;
              trig_out <= (dcnt == DELAY_W'(1));
            end
          end
          default: begin
            state <= ST_IDLE;
            armed <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge ADC_pl_clk or negedge ADC_pl_rst_n) begin
    if (!ADC_pl_rst_n)
      err_cnt <= '0;
    else if (clr_err)
      err_cnt <= '0;
    else if (lock_loss && err_cnt != ERR_MAX)
      err_cnt <= err_cnt + 1'b1;
  end

endmodule
`default_nettype wire
